// File: rtl/main_memory_port.sv
// Word-addressed backing store for the cache: accepts one read/write at a time
// and answers with a one-cycle MReady after a programmable number of wait states.
module main_memory_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy,
    output logic              MErr
);

    if (WAIT < 1 || WAIT > 255) begin : g_bad_wait
        $error("main_memory_port: WAIT must be in 1..255");
    end

    localparam logic [7:0] WAIT_LD = 8'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [7:0]        wcnt;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wcnt     <= 8'd0;
            req_rw   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            MDataOut <= '0;
            MReady   <= 1'b0;
            MBusy    <= 1'b0;
            MErr     <= 1'b0;
        end else begin
            MReady <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (MStrobe) begin
                        req_rw   <= MRW;
                        req_addr <= MAddr;
                        req_data <= MDataIn;
                        wcnt     <= WAIT_LD;
                        state    <= S_WAIT;
                        MBusy    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    wcnt <= wcnt - 8'd1;
                    if (MStrobe) MErr <= 1'b1;
                    if (wcnt == 8'd1) begin
                        state  <= S_DONE;
                        MReady <= 1'b1;
                        if (!req_rw) MDataOut <= mem[req_addr];
                    end
                end
                S_DONE: begin
                    if (MStrobe) MErr <= 1'b1;
                    state <= S_IDLE;
                    MBusy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    MBusy <= 1'b0;
                end
            endcase
        end
    end

    // Write commits on the edge leaving DONE; a reset on that edge discards it.
    always_ff @(posedge clk) begin
        if (!reset && state == S_DONE && req_rw) begin
            mem[req_addr] <= req_data;
        end
    end

endmodule

// File: tb/tb_main_memory_port.sv
// Randomised self-checking bench for main_memory_port (WAIT=4 and WAIT=1
// instances share stimulus) against an array-based memory model.
module tb_main_memory_port;

    localparam int WA = 4;
    localparam int WB = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        MStrobe;
    logic        MRW;
    logic [7:0]  MAddr;
    logic [31:0] MDataIn;
    logic [31:0] MDataOut, MDataOut1;
    logic        MReady, MReady1;
    logic        MBusy, MBusy1;
    logic        MErr, MErr1;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [256];
    bit          known [256];

    main_memory_port #(.ADDR_W(8), .DATA_W(32), .WAIT(WA)) dut (
        .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW),
        .MAddr(MAddr), .MDataIn(MDataIn), .MDataOut(MDataOut),
        .MReady(MReady), .MBusy(MBusy), .MErr(MErr)
    );

    main_memory_port #(.ADDR_W(8), .DATA_W(32), .WAIT(WB)) dut1 (
        .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW),
        .MAddr(MAddr), .MDataIn(MDataIn), .MDataOut(MDataOut1),
        .MReady(MReady1), .MBusy(MBusy1), .MErr(MErr1)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Called at a negedge; the strobe is sampled at the next posedge (E0).
    // Cycle k is the interval between Ek and Ek+1, sampled at its negedge.
    task automatic run_req(input logic rw, input logic [7:0] a,
                           input logic [31:0] d,
                           output int lat, output int bcnt,
                           output logic [31:0] rd,
                           output int lat1, output int bcnt1,
                           output logic [31:0] rd1);
        lat = -1; lat1 = -1; bcnt = 0; bcnt1 = 0;
        rd = 'x; rd1 = 'x;
        MStrobe = 1'b1; MRW = rw; MAddr = a; MDataIn = d;
        for (int k = 0; k < WA + 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                MStrobe = 1'b0;
                MRW     = 1'($urandom);
                MAddr   = 8'($urandom);
                MDataIn = $urandom;
            end
            if (MBusy) bcnt++;
            if (MBusy1) bcnt1++;
            if (MReady && lat < 0) begin lat = k; rd = MDataOut; end
            if (MReady1 && lat1 < 0) begin lat1 = k; rd1 = MDataOut1; end
            if (k > WA && !MBusy && !MBusy1) break;
        end
        if (rw) begin model[a] = d; known[a] = 1'b1; end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; MStrobe = 1'b0; MRW = 1'b0;
        MAddr = 8'h0; MDataIn = 32'h0;
        repeat (2) @(negedge clk);
        MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h10;
        @(negedge clk);
        checks++;
        if ({MBusy, MReady, MErr} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got busy/ready/err=%b want 000",
                     {MBusy, MReady, MErr});
        end
        checks++;
        if (MDataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h want 00000000", MDataOut);
        end
        reset = 1'b0; MStrobe = 1'b0;
        @(negedge clk);
        checks++;
        if (MBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe_ignored: got busy=%b want 0", MBusy);
        end
    endtask

    task automatic test_write_read;
        int lat, bc, lat1, bc1;
        logic [31:0] rd, rd1;
        run_req(1'b1, 8'h10, 32'hDEADBEEF, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (lat !== WA || bc !== WA + 1) begin
            errors++;
            $display("FAIL wr_timing: got ready@%0d busy=%0d want %0d/%0d",
                     lat, bc, WA, WA + 1);
        end
        run_req(1'b0, 8'h10, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (lat !== WA || bc !== WA + 1) begin
            errors++;
            $display("FAIL rd_timing: got ready@%0d busy=%0d want %0d/%0d",
                     lat, bc, WA, WA + 1);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_strobe_in_wait;
        int lat, bc, lat1, bc1, rdy_at;
        logic [31:0] rd, rd1, seen;
        rdy_at = -1; seen = 'x;
        checks++;
        if (MErr !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: got %b want 0", MErr);
        end
        MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h10; MDataIn = 32'h0;
        for (int k = 0; k < WA + 2; k++) begin
            @(negedge clk);
            MStrobe = 1'b0;
            if (k == 1) begin
                MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h10; MDataIn = 32'h1;
            end
            if (k == 2) begin
                checks++;
                if (MErr !== 1'b1) begin
                    errors++;
                    $display("FAIL err_set: got %b want 1", MErr);
                end
            end
            if (MReady && rdy_at < 0) begin rdy_at = k; seen = MDataOut; end
        end
        checks++;
        if (rdy_at !== WA || seen !== model[8'h10]) begin
            errors++;
            $display("FAIL err_inflight: got ready@%0d data=%h want %0d/%h",
                     rdy_at, seen, WA, model[8'h10]);
        end
        run_req(1'b0, 8'h10, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (rd !== model[8'h10]) begin
            errors++;
            $display("FAIL err_no_write: got %h want %h", rd, model[8'h10]);
        end
        checks++;
        if (MErr !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", MErr);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, bc, lat1, bc1, rdys;
        logic [31:0] rd, rd1;
        run_req(1'b1, 8'h20, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        rdys = 0;
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h20; MDataIn = 32'h12345678;
        @(negedge clk);
        MStrobe = 1'b0;
        if (MReady) rdys++;
        @(negedge clk);
        if (MReady) rdys++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({MBusy, MReady, MErr} !== 3'b000 || MDataOut !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outs: got b/r/e=%b dout=%h want 000/0",
                     {MBusy, MReady, MErr}, MDataOut);
        end
        reset = 1'b0;
        repeat (WA + 4) begin
            @(negedge clk);
            if (MReady) rdys++;
        end
        checks++;
        if (rdys !== 0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %0d pulses want 0", rdys);
        end
        run_req(1'b0, 8'h20, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h want 00000000", rd);
        end
    endtask

    task automatic test_addr_extremes;
        int lat, bc, lat1, bc1;
        logic [31:0] rd, rd1;
        run_req(1'b1, 8'hFF, 32'hAAAA5555, lat, bc, rd, lat1, bc1, rd1);
        run_req(1'b1, 8'h00, 32'h5555AAAA, lat, bc, rd, lat1, bc1, rd1);
        run_req(1'b0, 8'hFF, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (rd !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL addr_ff: got %h want aaaa5555", rd);
        end
        run_req(1'b0, 8'h00, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (rd !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL addr_00: got %h want 5555aaaa", rd);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc, lat1, bc1, bad, rdys;
        logic [31:0] rd, rd1, wd, bad_val;
        run_req(1'b0, 8'h10, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_read: got %h want deadbeef", rd);
        end
        wd = $urandom;
        bad = 0; rdys = 0; bad_val = 32'hDEADBEEF;
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h30; MDataIn = wd;
        for (int k = 0; k < WA + 2 + 10; k++) begin
            @(negedge clk);
            MStrobe = 1'b0;
            if (MReady) rdys++;
            if (MDataOut !== 32'hDEADBEEF) begin bad++; bad_val = MDataOut; end
        end
        model[8'h30] = wd; known[8'h30] = 1'b1;
        checks++;
        if (rdys !== 1) begin
            errors++;
            $display("FAIL b2b_accept: got %0d ready pulses want 1", rdys);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_hold: got %h in %0d cycles want deadbeef",
                     bad_val, bad);
        end
        run_req(1'b0, 8'h30, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (rd !== wd) begin
            errors++;
            $display("FAIL b2b_wdata: got %h want %h", rd, wd);
        end
    endtask

    task automatic test_min_latency;
        int lat, bc, lat1, bc1;
        logic [31:0] rd, rd1;
        run_req(1'b0, 8'h10, 32'h0, lat, bc, rd, lat1, bc1, rd1);
        checks++;
        if (lat1 !== WB || bc1 !== WB + 1) begin
            errors++;
            $display("FAIL min_lat: got ready@%0d busy=%0d want %0d/%0d",
                     lat1, bc1, WB, WB + 1);
        end
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL min_data: got %h want deadbeef", rd1);
        end
    endtask

    task automatic test_random;
        int lat, bc, lat1, bc1;
        logic [31:0] rd, rd1, d;
        logic [7:0] a;
        logic rw;
        for (int i = 0; i < 60; i++) begin
            a  = 8'($urandom);
            d  = $urandom;
            rw = 1'($urandom) || !known[a];
            run_req(rw, a, d, lat, bc, rd, lat1, bc1, rd1);
            checks++;
            if (lat !== WA || bc !== WA + 1 || lat1 !== WB || bc1 !== WB + 1) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                         i, lat, bc, lat1, bc1, WA, WA + 1, WB, WB + 1);
            end
            if (!rw) begin
                checks++;
                if (rd !== model[a]) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] addr %h: got %h want %h",
                             i, a, rd, model[a]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; MStrobe = 1'b0; MRW = 1'b0;
        MAddr = 8'h0; MDataIn = 32'h0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        test_reset();
        test_write_read();
        test_strobe_in_wait();
        test_reset_mid_write();
        test_addr_extremes();
        test_back_to_back();
        test_min_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
